// File: rtl/pps_led_walker.sv
`default_nettype none
// ============================================================================
// Module   : pps_led_walker
// Purpose  : Consumes the toggling 1 Hz divider output, synchronises it and
//            advances a bouncing one-hot LED pattern on every input edge
//            (rising or falling). A watchdog raises a flag when the upstream
//            divider stops toggling.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   NLEDS          number of LED outputs (>= 2)
//   TIMEOUT_CYCLES clock cycles without a toggle before o_stalled (>= 2)
// Ports:
//   i_clk      in   1      system clock
//   i_reset_n  in   1      asynchronous active-low reset
//   i_pps      in   1      toggling divider output (asynchronous)
//   o_led      out  NLEDS  one-hot LED pattern, registered
//   o_step     out  1      one-cycle strobe in the cycle after an advance
//   o_stalled  out  1      watchdog flag, registered
// ============================================================================
module pps_led_walker #(
  parameter int NLEDS          = 8,
  parameter int TIMEOUT_CYCLES = 9_000_000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_pps,
  output logic [NLEDS-1:0] o_led,
  output logic             o_step,
  output logic             o_stalled
);

  localparam int            PW       = $clog2(NLEDS);
  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] POS_LAST = PW'(NLEDS - 1);
  localparam logic [PW-1:0] POS_ZERO = PW'(0);
  localparam logic [PW-1:0] POS_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic          DIR_UP   = 1'b0;
  localparam logic          DIR_DOWN = 1'b1;

  // Local aliases so the sequential code reads in the design's own terms.
  logic clk;
  logic rst_n;
  assign clk   = i_clk;
  assign rst_n = i_reset_n;

  // Registered state
  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [1:0]    arm_cnt;
  logic          armed;
  logic [PW-1:0] pos;
  logic          dir;
  logic [CW-1:0] cnt;

  // Next-state values
  logic             step;
  logic [PW-1:0]    pos_next;
  logic             dir_next;
  logic [CW-1:0]    cnt_next;
  logic [NLEDS-1:0] led_next;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    step     = armed & (sync2 ^ prev);
    pos_next = pos;
    dir_next = dir;
    cnt_next = cnt;
    led_next = '0;

    // Bounce at either end: the end LED is lit once per pass, not twice.
    if (step) begin
      if (dir == DIR_UP) begin
        if (pos == POS_LAST) begin
          pos_next = POS_LAST - POS_ONE;
          dir_next = DIR_DOWN;
        end else begin
          pos_next = pos + POS_ONE;
        end
      end else begin
        if (pos == POS_ZERO) begin
          pos_next = POS_ONE;
          dir_next = DIR_UP;
        end else begin
          pos_next = pos - POS_ONE;
        end
      end
    end

    // Step takes priority over saturation, so a toggle arriving exactly at
    // the timeout edge still clears the stall flag.
    if (!armed || step) begin
      cnt_next = CNT_ZERO;
    end else if (cnt != CNT_MAX) begin
      cnt_next = cnt + CNT_ONE;
    end

    for (int i = 0; i < NLEDS; i++) begin
      led_next[i] = (pos_next == PW'(i));
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      prev      <= 1'b0;
      arm_cnt   <= 2'd0;
      armed     <= 1'b0;
      pos       <= POS_ZERO;
      dir       <= DIR_UP;
      cnt       <= CNT_ZERO;
      o_led     <= {{(NLEDS-1){1'b0}}, 1'b1};
      o_step    <= 1'b0;
      o_stalled <= 1'b0;
    end else begin
      sync1 <= i_pps;
      sync2 <= sync1;
      prev  <= sync2;

      // Arming waits until prev has caught up with sync2, so an input that is
      // already high at reset release never looks like an edge.
      if (!armed) begin
        if (arm_cnt == 2'd2) begin
          armed <= 1'b1;
        end else begin
          arm_cnt <= arm_cnt + 2'd1;
        end
      end

      pos       <= pos_next;
      dir       <= dir_next;
      cnt       <= cnt_next;
      o_led     <= led_next;
      o_step    <= step;
      o_stalled <= (cnt_next == CNT_MAX);
    end
  end

endmodule
`default_nettype wire
